muldiv_seq: RTL

Iterative multi-cycle multiply/divide sequencer for the RV32M instructions, sitting beside the ALU in the Execute stage. It accepts an M-extension operation from E and computes it with a radix-2 shift-add (multiply) or restoring (divide) datapath. It drives `BusyE` to the hazard unit, which holds F/D/E and bubbles M until the result is ready.

---
 rtl/muldiv_seq_if.sv | 23 ++
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake between the pipeline and the M-extension sequencer.
// The master issues the operation; the slave returns stall, done pulse and result.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            StartE;
  logic [2:0]      FunctE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            BusyE;
  logic            DoneE;
  logic [XLEN-1:0] ResultE;

  modport master (
    output StartE, FunctE, SrcAE, SrcBE,
    input  BusyE, DoneE, ResultE
  );

  modport slave (
    input  StartE, FunctE, SrcAE, SrcBE,
    output BusyE, DoneE, ResultE
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Operands are reduced to magnitudes on capture and the sign is restored on the final step.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           reset,
  muldiv_seq_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_next;
  logic [2:0]        r_funct;
  logic              r_sign_a, r_sign_b;
  logic [5:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [XLEN-1:0]   r_result;

  logic              w_busy, w_done;
  logic              w_is_div, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_fixed;

  // Operand decode at capture time
  always_comb begin
    w_is_div   = bus.FunctE[2];
    w_a_signed = w_is_div ? ~bus.FunctE[0] : (bus.FunctE[1:0] != 2'b11);
    w_b_signed = w_is_div ? ~bus.FunctE[0] : ~bus.FunctE[1];
    w_sign_a   = w_a_signed & bus.SrcAE[XLEN-1];
    w_sign_b   = w_b_signed & bus.SrcBE[XLEN-1];
    w_mag_a    = w_sign_a ? -bus.SrcAE : bus.SrcAE;
    w_mag_b    = w_sign_b ? -bus.SrcBE : bus.SrcBE;
    w_div_zero = w_is_div & (bus.SrcBE == '0);
    w_div_ovf  = w_is_div & ~bus.FunctE[0] & (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &
                 (bus.SrcBE == '1);
    w_special  = w_div_zero | w_div_ovf;
    if (w_div_zero) begin
      w_special_res = bus.FunctE[1] ? bus.SrcAE : '1;
    end else begin
      w_special_res = bus.FunctE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration step; r_acc is {hi, lo} for multiply and {remainder, quotient} for divide
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mul_next = {w_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_diff     = w_rem_sh - {1'b0, r_opb};
    if (w_diff[XLEN]) begin
      w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
    w_acc_next = r_funct[2] ? w_div_next : w_mul_next;
  end

  // Sign restoration applied to the final iteration's value
  always_comb begin
    w_prod = (r_sign_a ^ r_sign_b) ? -w_acc_next : w_acc_next;
    w_quot = w_acc_next[XLEN-1:0];
    w_rem  = w_acc_next[2*XLEN-1:XLEN];
    if (!r_funct[2]) begin
      w_fixed = (r_funct[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else if (!r_funct[1]) begin
      w_fixed = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
    end else begin
      w_fixed = r_sign_a ? -w_rem : w_rem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.StartE) begin
          w_busy       = 1'b1;
          w_state_next = w_special ? StDone : StRun;
        end
      end
      StRun: begin
        w_busy = 1'b1;
        if (r_cnt == 6'd1) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_funct  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.StartE) begin
            r_funct  <= bus.FunctE;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            if (w_special) begin
              r_result <= w_special_res;
            end else begin
              r_cnt <= 6'(XLEN);
              r_acc <= {{XLEN{1'b0}}, w_mag_a};
              r_opb <= w_mag_b;
            end
          end
        end
        StRun: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_result <= w_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BusyE   = w_busy;
  assign bus.DoneE   = w_done;
  assign bus.ResultE = r_result;

endmodule
